// File: rtl/cla4_stage64_pkg.sv
// Shared constants and carry-lookahead helpers for the 64-bit, 4-stage pipelined adder.
package cla4_stage64_pkg;

   localparam int DATA_W     = 64;
   localparam int SLICE_W    = 16;
   localparam int NUM_STAGES = 4;
   localparam int GROUP_W    = 4;

   // Carry into each position of a GROUP_W-wide block, every term expanded flat (no ripple).
   function automatic logic [GROUP_W-1:0] lookahead_carries(
      input logic [GROUP_W-1:0] g,
      input logic [GROUP_W-1:0] p,
      input logic               cin
   );
      logic [GROUP_W-1:0] c;
      logic               term;
      for (int i = 0; i < GROUP_W; i++) begin
         c[i] = cin;
         for (int k = 0; k < i; k++) c[i] &= p[k];
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int k = j + 1; k < i; k++) term &= p[k];
            c[i] |= term;
         end
      end
      return c;
   endfunction

   function automatic logic group_generate(
      input logic [GROUP_W-1:0] g,
      input logic [GROUP_W-1:0] p
   );
      logic gg;
      logic term;
      gg = 1'b0;
      for (int j = 0; j < GROUP_W; j++) begin
         term = g[j];
         for (int k = j + 1; k < GROUP_W; k++) term &= p[k];
         gg |= term;
      end
      return gg;
   endfunction

endpackage

// File: rtl/cla4_stage64_if.sv
// Operand/result bundle of the pipelined adder; the master drives operands.
interface cla4_stage64_if;
   import cla4_stage64_pkg::*;

   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [DATA_W:0]   out_sum;

   modport master (output in_a, output in_b, input out_sum);
   modport slave  (input in_a, input in_b, output out_sum);
endinterface

// File: rtl/cla4_stage64_cla16_slice.sv
// Combinational 16-bit two-level carry-lookahead adder slice.
module cla16_slice
   import cla4_stage64_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);

   localparam int NUM_GROUPS = SLICE_W / GROUP_W;

   logic [SLICE_W-1:0]    g;
   logic [SLICE_W-1:0]    p;
   logic [SLICE_W-1:0]    c;
   logic [NUM_GROUPS-1:0] grp_g;
   logic [NUM_GROUPS-1:0] grp_p;
   logic [NUM_GROUPS-1:0] grp_c;

   assign g = a & b;
   assign p = a ^ b;

   for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_group
      assign grp_g[gi] = group_generate(g[GROUP_W*gi +: GROUP_W], p[GROUP_W*gi +: GROUP_W]);
      assign grp_p[gi] = &p[GROUP_W*gi +: GROUP_W];
      assign c[GROUP_W*gi +: GROUP_W] =
         lookahead_carries(g[GROUP_W*gi +: GROUP_W], p[GROUP_W*gi +: GROUP_W], grp_c[gi]);
   end

   // Second lookahead level: group carries straight from group G/P and cin.
   assign grp_c = lookahead_carries(grp_g, grp_p, cin);
   assign cout  = group_generate(grp_g, grp_p) | (&grp_p & cin);
   assign sum   = p ^ c;

endmodule

// File: rtl/cla4_stage64.sv
// 64-bit adder pipelined as four 16-bit CLA stages with operand skew and sum deskew.
module cla4_stage64
   import cla4_stage64_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   cla4_stage64_if.slave  bus
);

   for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      localparam int LO = gi * SLICE_W;
      localparam int HI = LO + SLICE_W - 1;

      // Operands still pending for this and later stages; lower sums accumulate in sum_reg.
      logic [DATA_W-1:LO]  a_op;
      logic [DATA_W-1:LO]  b_op;
      logic                cin;
      logic [SLICE_W-1:0]  slice_sum;
      logic                slice_cout;
      logic [HI:0]         sum_next;
      logic [HI:0]         sum_reg;
      logic                carry_reg;

      if (gi == 0) begin : g_head
         assign a_op     = bus.in_a;
         assign b_op     = bus.in_b;
         assign cin      = 1'b0;
         assign sum_next = slice_sum;
      end else begin : g_tail
         assign a_op     = g_stage[gi-1].g_skew.a_skew_reg;
         assign b_op     = g_stage[gi-1].g_skew.b_skew_reg;
         assign cin      = g_stage[gi-1].carry_reg;
         assign sum_next = {slice_sum, g_stage[gi-1].sum_reg};
      end

      cla16_slice u_slice (
         .a    (a_op[HI:LO]),
         .b    (b_op[HI:LO]),
         .cin  (cin),
         .sum  (slice_sum),
         .cout (slice_cout)
      );

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            sum_reg   <= '0;
            carry_reg <= 1'b0;
         end else begin
            sum_reg   <= sum_next;
            carry_reg <= slice_cout;
         end
      end

      if (gi < NUM_STAGES - 1) begin : g_skew
         logic [DATA_W-1:HI+1] a_skew_reg;
         logic [DATA_W-1:HI+1] b_skew_reg;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               a_skew_reg <= '0;
               b_skew_reg <= '0;
            end else begin
               a_skew_reg <= a_op[DATA_W-1:HI+1];
               b_skew_reg <= b_op[DATA_W-1:HI+1];
            end
         end
      end
   end

   assign bus.out_sum = {g_stage[NUM_STAGES-1].carry_reg, g_stage[NUM_STAGES-1].sum_reg};

endmodule

// File: tb/tb_cla4_stage64.sv
// Directed and random checks of the pipelined adder: reset, latency, carries, streaming.
module tb_cla4_stage64;
   import cla4_stage64_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   cla4_stage64_if bus ();

   cla4_stage64 dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] sa[$];
   logic [63:0] sb[$];
   logic [64:0] sexp[$];

   task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic drive(input logic [63:0] a, input logic [63:0] b);
      bus.in_a = a;
      bus.in_b = b;
   endtask

   // Called on a falling edge: sum must be valid after 4 rising edges and still hold after 5.
   task automatic hold_check(input string tag, input logic [63:0] a, input logic [63:0] b,
                             input logic [64:0] exp);
      drive(a, b);
      repeat (4) @(negedge clock);
      check_eq({tag, "_lat4"}, bus.out_sum, exp);
      @(negedge clock);
      check_eq({tag, "_hold"}, bus.out_sum, exp);
   endtask

   // One new pair per cycle; result c-4 is due on the c-th falling edge.
   task automatic run_stream(input string tag);
      int n;
      n = sa.size();
      for (int c = 0; c < n + 4; c++) begin
         if (c >= 4) check_eq(tag, bus.out_sum, sexp[c-4]);
         if (c < n) drive(sa[c], sb[c]);
         @(negedge clock);
      end
      sa.delete();
      sb.delete();
      sexp.delete();
   endtask

   initial begin
      logic [63:0] ra;
      logic [63:0] rb;

      // Reset held with arbitrary operands
      drive(64'hDEAD_BEEF_0123_4567, 64'hFFFF_0000_FFFF_0000);
      repeat (3) @(negedge clock);
      check_eq("reset_hold", bus.out_sum, 65'h0);

      // Release with 1 + 2: zero for three edges, 3 after the fourth
      drive(64'd1, 64'd2);
      reset = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clock);
         check_eq($sformatf("release_pre%0d", i), bus.out_sum, 65'h0);
      end
      @(negedge clock);
      check_eq("release_sum", bus.out_sum, 65'd3);

      hold_check("max_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 65'h1_FFFF_FFFF_FFFF_FFFE);
      hold_check("ones_plus1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65'h1_0000_0000_0000_0000);
      hold_check("bnd15", 64'h0000_0000_0000_FFFF, 64'd1, 65'h0_0000_0000_0001_0000);
      hold_check("bnd31", 64'h0000_0000_FFFF_FFFF, 64'd1, 65'h0_0000_0001_0000_0000);
      hold_check("bnd47", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 65'h0_0001_0000_0000_0000);
      hold_check("gen31", 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000,
                 65'h0_0000_0001_0000_0000);
      hold_check("gen47", 64'h0000_8000_0000_0000, 64'h0000_8000_0000_0000,
                 65'h0_0001_0000_0000_0000);
      hold_check("zero", 64'd0, 64'd0, 65'h0);
      hold_check("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
                 65'h0_2222_2222_2222_2211);

      // Back-to-back directed pairs
      sa.push_back(64'd1); sb.push_back(64'd1); sexp.push_back(65'd2);
      sa.push_back(64'd2); sb.push_back(64'd2); sexp.push_back(65'd4);
      sa.push_back(64'd3); sb.push_back(64'd3); sexp.push_back(65'd6);
      sa.push_back(64'hFFFF_FFFF_FFFF_FFFF); sb.push_back(64'd1);
      sexp.push_back(65'h1_0000_0000_0000_0000);
      run_stream("b2b");

      // Reset mid-flight: valid output present, three more operations in the pipe
      hold_check("pre_flush", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65'h1_0000_0000_0000_0000);
      drive(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clock);
      drive(64'h0000_0000_FFFF_FFFF, 64'd1);
      @(negedge clock);
      drive(64'd7, 64'd8);
      @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      check_eq("async_flush", bus.out_sum, 65'h0);
      @(negedge clock);
      drive(64'd5, 64'd6);
      reset = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clock);
         check_eq($sformatf("flush_pre%0d", i), bus.out_sum, 65'h0);
      end
      @(negedge clock);
      check_eq("flush_sum", bus.out_sum, 65'd11);

      // Random pairs, each held five cycles
      for (int i = 0; i < 300; i++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         hold_check($sformatf("rand%0d", i), ra, rb, {1'b0, ra} + {1'b0, rb});
      end

      // Random back-to-back stream
      for (int i = 0; i < 200; i++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         sa.push_back(ra);
         sb.push_back(rb);
         sexp.push_back({1'b0, ra} + {1'b0, rb});
      end
      run_stream("rand_stream");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
